frame_stream_ctrl: RTL

FRAME_STREAM_CTRL -- requirements
Module: frame_stream_ctrl

---
 rtl/frame_stream_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/frame_stream_ctrl.sv
// frame_stream_ctrl: frame ingest FSM that feeds an external kernel and buffers its results in an output FIFO.
// Define FRAME_STREAM_PERF_CNT_EN to build the busy-cycle and input-stall counters.
module frame_stream_ctrl #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 960,
    parameter int PIX_W      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int SLACK      = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [PIX_W-1:0]              in_data,
    output logic                          in_ready,
    output logic                          feed_valid,
    output logic [PIX_W-1:0]              feed_data,
    input  logic                          proc_valid,
    input  logic [PIX_W-1:0]              proc_data,
    input  logic                          rd_en,
    output logic [PIX_W-1:0]              rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   pixels_in,
    output logic [31:0]                   pixels_out,
    output logic [1:0]                    state,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [31:0]                   cycle_count,
    output logic [31:0]                   stall_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [LW-1:0] LVL_ONE    = LW'(1);
    localparam logic [LW-1:0] LVL_FULL   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_LIMIT  = LW'(FIFO_DEPTH - SLACK);
    localparam logic [31:0]   FRAME_PIX  = 32'(IMG_W * IMG_H);
    localparam logic [31:0]   CNT_MAX    = 32'hFFFF_FFFF;
    localparam logic [4:0]    QUIET_LAST = 5'd15;

    typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t             state_r;
    logic [PIX_W-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]      level_r;
    logic [4:0]         quiet_r;
    logic [31:0]        pixels_in_r, pixels_out_r;
    logic               overflow_r, feed_valid_r, rd_valid_r;
    logic [PIX_W-1:0]   feed_data_r, rd_data_r;

    logic in_ready_s, accept_s, rd_ok_s, wr_ok_s, drop_s, quiet_s;
    logic fifo_full_s, fifo_empty_s, start_ok_s, busy_s;

    // Handshake and FIFO qualification; a full FIFO still accepts a write when a read frees a slot.
    always_comb begin
        fifo_full_s  = (level_r == LVL_FULL);
        fifo_empty_s = (level_r == '0);
        busy_s       = (state_r == FEED) || (state_r == DRAIN);
        start_ok_s   = start && ((state_r == IDLE) || (state_r == DONE));
        in_ready_s   = (state_r == FEED) && (level_r < LVL_LIMIT);
        accept_s     = in_valid && in_ready_s;
        rd_ok_s      = rd_en && !fifo_empty_s;
        wr_ok_s      = proc_valid && (state_r != IDLE) && (!fifo_full_s || rd_ok_s);
        drop_s       = proc_valid && (state_r != IDLE) && fifo_full_s && !rd_en;
        quiet_s      = fifo_empty_s && !feed_valid_r && !proc_valid;
    end

    // Frame FSM, feed register and frame statistics; start clears take priority over same-cycle increments.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= IDLE;
            quiet_r      <= 5'd0;
            pixels_in_r  <= 32'd0;
            pixels_out_r <= 32'd0;
            overflow_r   <= 1'b0;
            feed_valid_r <= 1'b0;
            feed_data_r  <= '0;
        end else begin
            feed_valid_r <= accept_s;
            if (accept_s) feed_data_r <= in_data;
            if (accept_s && (pixels_in_r != CNT_MAX)) pixels_in_r <= pixels_in_r + 32'd1;
            if (wr_ok_s && (pixels_out_r != CNT_MAX)) pixels_out_r <= pixels_out_r + 32'd1;
            if (drop_s) overflow_r <= 1'b1;
            case (state_r)
                IDLE, DONE: begin
                    if (start_ok_s) begin
                        state_r      <= FEED;
                        pixels_in_r  <= 32'd0;
                        pixels_out_r <= 32'd0;
                        overflow_r   <= 1'b0;
                    end
                end
                FEED: begin
                    if (accept_s && (pixels_in_r == FRAME_PIX - 32'd1)) state_r <= DRAIN;
                end
                DRAIN: begin
                    // Sixteen consecutive quiet cycles mean the kernel has nothing left in flight.
                    if (quiet_s) begin
                        if (quiet_r == QUIET_LAST) begin
                            state_r <= DONE;
                            quiet_r <= 5'd0;
                        end else begin
                            quiet_r <= quiet_r + 5'd1;
                        end
                    end else begin
                        quiet_r <= 5'd0;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy and registered read port.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            rd_valid_r <= rd_ok_s;
            if (rd_ok_s) begin
                rd_data_r <= mem_r[rd_ptr_r];
                rd_ptr_r  <= rd_ptr_r + PTR_ONE;
            end
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            case ({wr_ok_s, rd_ok_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok_s) mem_r[wr_ptr_r] <= proc_data;
    end

`ifdef FRAME_STREAM_PERF_CNT_EN
    logic [31:0] cycle_count_r, stall_count_r;

    // Saturating busy-cycle and input-stall counters, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cycle_count_r <= 32'd0;
            stall_count_r <= 32'd0;
        end else if (start_ok_s) begin
            cycle_count_r <= 32'd0;
            stall_count_r <= 32'd0;
        end else begin
            if (busy_s && (cycle_count_r != CNT_MAX)) cycle_count_r <= cycle_count_r + 32'd1;
            if ((state_r == FEED) && in_valid && !in_ready_s && (stall_count_r != CNT_MAX))
                stall_count_r <= stall_count_r + 32'd1;
        end
    end

    assign cycle_count = cycle_count_r;
    assign stall_count = stall_count_r;
`else
    assign cycle_count = 32'd0;
    assign stall_count = 32'd0;
`endif

    assign in_ready   = in_ready_s;
    assign feed_valid = feed_valid_r;
    assign feed_data  = feed_data_r;
    assign rd_valid   = rd_valid_r;
    assign rd_data    = rd_data_r;
    assign fifo_level = level_r;
    assign pixels_in  = pixels_in_r;
    assign pixels_out = pixels_out_r;
    assign overflow   = overflow_r;
    assign state      = state_r;
    assign busy       = busy_s;
    assign done       = (state_r == DONE);

endmodule
